// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared state encodings and default width for the restoring divider
package restoring_divider_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/result width
    localparam int DEFAULT_WIDTH = 4;

    // Width of the step counter that must hold 0..width-1 (at least one bit)
    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/restoring_divider_div_step.sv
// rtl/restoring_divider_div_step.sv - one combinational restoring shift-subtract step
module div_step
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_out,
    output logic             q_bit
);

    // The stored partial remainder is always below the divisor, so it fits in
    // WIDTH bits; only the shifted trial value needs the extra top bit.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] reduced;

    // Shift in the next dividend bit and subtract when the divisor fits
    always_comb begin
        trial   = {p_in, dividend_bit};
        // Modular WIDTH-bit subtraction is exact here: the true difference is
        // below the divisor whenever it is used.
        reduced = trial[WIDTH-1:0] - divisor;
        if (trial >= {1'b0, divisor}) begin
            q_bit = 1'b1;
            p_out = reduced;
        end else begin
            q_bit = 1'b0;
            p_out = trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider with start/done handshake
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    // Working registers. The dividend register shifts left once per step: its
    // MSB feeds the step and the new quotient bit enters at the LSB, so after
    // WIDTH steps it holds the full quotient.
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] partial;
    logic [CW-1:0]    step_count;

    logic [WIDTH-1:0] step_p;
    logic             step_q;
    logic             accept;
    logic             last_step;

    // A request is honoured whenever no division is running
    assign accept    = start && (state != RUN);
    assign last_step = (step_count == LAST_STEP);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p_in        (partial),
        .dividend_bit(work[WIDTH-1]),
        .divisor     (divisor_q),
        .p_out       (step_p),
        .q_bit       (step_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new request just like IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-step datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            work        <= '0;
            divisor_q   <= '0;
            partial     <= '0;
            step_count  <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            work       <= dividend;
            divisor_q  <= divisor;
            partial    <= '0;
            step_count <= '0;
            // A zero divisor skips RUN, so its results are loaded right here
            // on the way into DONE.
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            work       <= {work[WIDTH-2:0], step_q};
            partial    <= step_p;
            step_count <= step_count + 1'b1;
            if (last_step) begin
                quotient    <= {work[WIDTH-2:0], step_q};
                remainder   <= step_p;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard bench for restoring_divider at WIDTH=4
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    restoring_divider #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Small shift-add 2x2 multiplier used for the round-trip check
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] acc;
        acc = 4'd0;
        if (y[0]) acc = acc + {2'b00, x};
        if (y[1]) acc = acc + {1'b0, x, 1'b0};
        return acc;
    endfunction

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_quotient", quotient, mon_e.q);
                check("sb_remainder", remainder, mon_e.r);
                check("sb_div_by_zero", div_by_zero, mon_e.z);
            end
        end
    end

    // Called at a negedge: drive a request and record its expected result
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
    endtask

    // One complete operation with busy/done timing checked cycle by cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r);
        int lat;
        @(negedge clk);
        start_op(a, b);
        lat = (b == 0) ? 1 : W + 1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check($sformatf("busy_c%0d_%0d_%0d", k, a, b), busy, (k < lat) ? 1 : 0);
            check($sformatf("done_c%0d_%0d_%0d", k, a, b), done, (k == lat) ? 1 : 0);
        end
        q = quotient;
        r = remainder;
    endtask

    logic [W-1:0] q;
    logic [W-1:0] r;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        rst = 1'b0;

        run_op(4'd13, 4'd3, q, r);
        check("q_13_3", q, 4);
        check("r_13_3", r, 1);
        check("z_13_3", div_by_zero, 0);

        run_op(4'd15, 4'd1, q, r);
        check("q_15_1", q, 15);
        check("r_15_1", r, 0);

        run_op(4'd2, 4'd5, q, r);
        check("q_2_5", q, 0);
        check("r_2_5", r, 2);

        run_op(4'd7, 4'd0, q, r);
        check("q_7_0", q, 15);
        check("r_7_0", r, 7);
        check("z_7_0", div_by_zero, 1);

        // Abort 9/2 with rst in cycle 2: no done, everything cleared
        @(negedge clk);
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        run_op(4'd9, 4'd2, q, r);
        check("q_9_2", q, 4);
        check("r_9_2", r, 1);

        // Back-to-back: 12/4 requested in the done cycle of 13/3; a start
        // during busy (with changed operands) must be ignored
        @(negedge clk);
        start_op(4'd13, 4'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                dividend = 4'd1;
                divisor  = 4'd1;
                start    = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (k == 5) begin
                check("b2b_first_done", done, 1);
                check("b2b_first_q", quotient, 4);
                start_op(4'd12, 4'd4);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next", busy, 1);
        check("b2b_held_q", quotient, 4);
        check("b2b_held_r", remainder, 1);
        for (int k = 7; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("b2b_done_c%0d", k), done, (k == 10) ? 1 : 0);
        end
        check("b2b_q_12_4", quotient, 3);
        check("b2b_r_12_4", remainder, 0);

        // Exhaustive operand sweep with invariant and multiplier round-trip
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b), q, r);
                if (b != 0) begin
                    check($sformatf("inv_%0d_%0d", a, b), 32'(q) * 32'(b) + 32'(r), a);
                    check($sformatf("rlt_%0d_%0d", a, b), (32'(r) < 32'(b)) ? 1 : 0, 1);
                    if (q < 4 && b < 4) begin
                        check($sformatf("mul_%0d_%0d", a, b),
                              32'(mul2(q[1:0], 2'(b))) + 32'(r), a);
                    end
                end
            end
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
